// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: 16-bit sequential ALU.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/NOT, DIV by zero) deliver at the edge
// that accepts start. MUL (shift-add) and DIV (restoring) iterate 16 times
// in EXEC and deliver at the 16th iteration edge.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   start    in   operation request, sampled in IDLE only
//   opcode   in   3b: ADD,SUB,AND,OR,XOR,NOT,MUL,DIV
//   op_a     in   16b first operand
//   op_b     in   16b second operand
//   ALU_rez  out  16b registered result, held until the next result
//   str_rez  out  one-cycle strobe marking a new ALU_rez
//   busy     out  high while MUL/DIV iterates
//   zero     out  ALU_rez == 0
//   carry    out  ADD carry-out / SUB borrow, 0 otherwise
//   div0     out  last result was a divide by zero
// ---------------------------------------------------------------------------
module alu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  opcode,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic [15:0] ALU_rez,
   output logic        str_rez,
   output logic        busy,
   output logic        zero,
   output logic        carry,
   output logic        div0
);

   localparam int unsigned W     = 16;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic {IDLE, EXEC} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       op_q,    op_d;
   logic [W-1:0]     a_q,     a_d;     // MUL: shifted multiplicand; DIV: dividend -> quotient
   logic [W-1:0]     b_q,     b_d;     // MUL: shifted multiplier;   DIV: divisor
   logic [W-1:0]     acc_q,   acc_d;   // MUL: partial product;      DIV: partial remainder
   logic [W-1:0]     rez_q,   rez_d;
   logic             str_q,   str_d;
   logic             busy_q,  busy_d;
   logic             zero_q,  zero_d;
   logic             carry_q, carry_d;
   logic             div0_q,  div0_d;

   // single-cycle datapath, fed straight from the inputs
   logic [W:0]   add_ext;
   logic [W-1:0] alu_res;
   logic         alu_carry;

   // iteration datapath
   logic [W:0]   rem_sh;
   logic [W:0]   rem_sub;
   logic [W-1:0] acc_nx;
   logic [W-1:0] quo_nx;
   logic [W-1:0] res_nx;

   // Combinational single-cycle ALU
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      add_ext   = {1'b0, op_a} + {1'b0, op_b};
      case (opcode)
         OP_ADD: begin
            alu_res   = add_ext[W-1:0];
            alu_carry = add_ext[W];
         end
         OP_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a < op_b);
         end
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOT:  alu_res = ~op_a;
         default: alu_res = '0;
      endcase
   end

   // One MUL or DIV iteration from the current working registers
   always_comb begin
      // remainder never reaches the divisor, so the shifted value fits in W+1 bits
      rem_sh  = {acc_q, a_q[W-1]};
      rem_sub = rem_sh - {1'b0, b_q};
      acc_nx  = acc_q;
      quo_nx  = a_q;
      res_nx  = acc_q;
      if (op_q == OP_MUL) begin
         acc_nx = b_q[0] ? (acc_q + a_q) : acc_q;
         res_nx = acc_nx;
      end else begin
         // no borrow means the divisor fits: keep the difference, quotient bit 1
         if (!rem_sub[W]) begin
            acc_nx = rem_sub[W-1:0];
            quo_nx = {a_q[W-2:0], 1'b1};
         end else begin
            acc_nx = rem_sh[W-1:0];
            quo_nx = {a_q[W-2:0], 1'b0};
         end
         res_nx = quo_nx;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      rez_d   = rez_q;
      str_d   = 1'b0;
      busy_d  = busy_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      div0_d  = div0_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = opcode;
               a_d   = op_a;
               b_d   = op_b;
               acc_d = '0;
               cnt_d = '0;
               if (opcode == OP_MUL || (opcode == OP_DIV && op_b != '0)) begin
                  state_d = EXEC;
                  busy_d  = 1'b1;
               end else if (opcode == OP_DIV) begin
                  rez_d   = 16'hFFFF;
                  zero_d  = 1'b0;
                  carry_d = 1'b0;
                  div0_d  = 1'b1;
                  str_d   = 1'b1;
               end else begin
                  rez_d   = alu_res;
                  zero_d  = (alu_res == '0);
                  carry_d = alu_carry;
                  div0_d  = 1'b0;
                  str_d   = 1'b1;
               end
            end
         end
         EXEC: begin
            acc_d = acc_nx;
            if (op_q == OP_MUL) begin
               a_d = a_q << 1;
               b_d = b_q >> 1;
            end else begin
               a_d = quo_nx;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               rez_d   = res_nx;
               zero_d  = (res_nx == '0);
               carry_d = 1'b0;
               div0_d  = 1'b0;
               str_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         rez_q   <= '0;
         str_q   <= 1'b0;
         busy_q  <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         rez_q   <= rez_d;
         str_q   <= str_d;
         busy_q  <= busy_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         div0_q  <= div0_d;
      end
   end

   assign ALU_rez = rez_q;
   assign str_rez = str_q;
   assign busy    = busy_q;
   assign zero    = zero_q;
   assign carry   = carry_q;
   assign div0    = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq: self-checking bench for alu_seq. Directed scenarios plus a
// randomized sweep compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  opcode;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [15:0] ALU_rez;
   logic        str_rez;
   logic        busy;
   logic        zero;
   logic        carry;
   logic        div0;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .opcode  (opcode),
      .op_a    (op_a),
      .op_b    (op_b),
      .ALU_rez (ALU_rez),
      .str_rez (str_rez),
      .busy    (busy),
      .zero    (zero),
      .carry   (carry),
      .div0    (div0)
   );

   always #5 clk = ~clk;

   // Reference model: result and flags straight from the operation definitions
   function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic c, output logic d, output int lat);
      int unsigned s;
      c = 1'b0; d = 1'b0; lat = 0;
      case (op)
         3'd0: begin s = 32'(a) + 32'(b); r = 16'(s); c = (s > 32'd65535); end
         3'd1: begin r = 16'(a - b); c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = ~a;
         3'd6: begin r = 16'((32'(a) * 32'(b)) % 32'd65536); lat = 16; end
         default: begin
            if (b == 16'd0) begin r = 16'hFFFF; d = 1'b1; end
            else begin r = 16'(a / b); lat = 16; end
         end
      endcase
   endfunction

   // Issue one operation and wait (bounded) for its strobe; lat = -1 on timeout
   task automatic exec_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit scramble, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; opcode = op; op_a = a; op_b = b;
      lat = -1; bcnt = 0;
      for (int i = 0; i <= 24; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            start = 1'b0;
            if (scramble) begin
               opcode = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
            end
         end
         if (busy) bcnt++;
         if (str_rez) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b1; opcode = 3'd0; op_a = 16'hFFFF; op_b = 16'h0001;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({ALU_rez, str_rez, busy, zero, carry, div0} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rez=%h str=%b busy=%b z=%b c=%b d0=%b, want all 0",
                  ALU_rez, str_rez, busy, zero, carry, div0);
      end
      @(negedge clk);
      start = 1'b0; reset = 1'b1;
   endtask

   task automatic test_add;
      int lat, bc;
      exec_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, lat, bc);
      n_tests++;
      if (lat !== 0 || ALU_rez !== 16'h0000 || carry !== 1'b1 || zero !== 1'b1 || div0 !== 1'b0) begin
         n_fail++;
         $display("FAIL add_wrap: got lat=%0d rez=%h c=%b z=%b d0=%b, want lat=0 rez=0000 c=1 z=1 d0=0",
                  lat, ALU_rez, carry, zero, div0);
      end
      @(posedge clk); #1;
      n_tests++;
      if (str_rez !== 1'b0 || ALU_rez !== 16'h0000) begin
         n_fail++;
         $display("FAIL add_strobe_width: got str=%b rez=%h, want str=0 rez=0000", str_rez, ALU_rez);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      start = 1'b1; opcode = 3'd1; op_a = 16'h0FFF; op_b = 16'h1000;
      @(posedge clk); #1;
      n_tests++;
      if (str_rez !== 1'b1 || ALU_rez !== 16'hFFFF || carry !== 1'b1 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_borrow: got str=%b rez=%h c=%b z=%b, want str=1 rez=FFFF c=1 z=0",
                  str_rez, ALU_rez, carry, zero);
      end
      opcode = 3'd2; op_a = 16'hFF01; op_b = 16'h0FFF;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (str_rez !== 1'b1 || ALU_rez !== 16'h0F01 || carry !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_and: got str=%b rez=%h c=%b, want str=1 rez=0F01 c=0", str_rez, ALU_rez, carry);
      end
      @(posedge clk); #1;
      n_tests++;
      if (str_rez !== 1'b0 || ALU_rez !== 16'h0F01) begin
         n_fail++;
         $display("FAIL b2b_end: got str=%b rez=%h, want str=0 rez=0F01", str_rez, ALU_rez);
      end
   endtask

   task automatic test_mul;
      int lat, bc;
      exec_op(3'd6, 16'h0123, 16'h0010, 1'b1, lat, bc);
      n_tests++;
      if (lat !== 16 || bc !== 16 || ALU_rez !== 16'h1230 || busy !== 1'b0 || carry !== 1'b0 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_basic: got lat=%0d busy_cycles=%0d rez=%h busy=%b c=%b z=%b, want 16 16 1230 0 0 0",
                  lat, bc, ALU_rez, busy, carry, zero);
      end
   endtask

   task automatic test_div;
      int lat, bc;
      exec_op(3'd7, 16'hFF01, 16'h000F, 1'b1, lat, bc);
      n_tests++;
      if (lat !== 16 || bc !== 16 || ALU_rez !== 16'h1100 || div0 !== 1'b0) begin
         n_fail++;
         $display("FAIL div_basic: got lat=%0d busy_cycles=%0d rez=%h d0=%b, want 16 16 1100 0",
                  lat, bc, ALU_rez, div0);
      end
      exec_op(3'd7, 16'h1234, 16'h0000, 1'b0, lat, bc);
      n_tests++;
      if (lat !== 0 || bc !== 0 || ALU_rez !== 16'hFFFF || div0 !== 1'b1 || carry !== 1'b0 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL div_zero: got lat=%0d busy_cycles=%0d rez=%h d0=%b c=%b z=%b, want 0 0 FFFF 1 0 0",
                  lat, bc, ALU_rez, div0, carry, zero);
      end
   endtask

   task automatic test_start_ignored;
      logic [15:0] a, b, r;
      logic        c, d;
      int          lat, pulses;
      a = 16'($urandom); b = 16'($urandom);
      model(3'd6, a, b, r, c, d, lat);
      pulses = 0;
      @(negedge clk);
      start = 1'b1; opcode = 3'd6; op_a = a; op_b = b;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         // re-request during busy with different ops; must be dropped
         start  = (i >= 2 && i <= 12 && (i % 3) != 0);
         opcode = 3'd0; op_a = 16'h0001; op_b = 16'h0001;
         if (str_rez) pulses++;
      end
      start = 1'b0;
      n_tests++;
      if (pulses !== 1 || ALU_rez !== r) begin
         n_fail++;
         $display("FAIL start_during_busy: got pulses=%0d rez=%h, want pulses=1 rez=%h", pulses, ALU_rez, r);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bc, pulses;
      exec_op(3'd0, 16'h1234, 16'h1111, 1'b0, lat, bc);
      @(negedge clk);
      start = 1'b1; opcode = 3'd6; op_a = 16'h00FF; op_b = 16'h0003;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      n_tests++;
      if ({ALU_rez, str_rez, busy, zero, carry, div0} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_mid_mul: got rez=%h str=%b busy=%b z=%b c=%b d0=%b, want all 0",
                  ALU_rez, str_rez, busy, zero, carry, div0);
      end
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (str_rez || busy) pulses++;
      end
      n_tests++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL reset_abandon: got %0d strobe/busy cycles after release, want 0", pulses);
      end
      exec_op(3'd0, 16'h0001, 16'h0001, 1'b0, lat, bc);
      n_tests++;
      if (lat !== 0 || ALU_rez !== 16'h0002 || carry !== 1'b0 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL add_after_reset: got lat=%0d rez=%h c=%b z=%b, want 0 0002 0 0", lat, ALU_rez, carry, zero);
      end
   endtask

   task automatic test_random;
      logic [2:0]  op;
      logic [15:0] a, b, r;
      logic        c, d;
      int          elat, lat, bc;
      for (int n = 0; n < 48; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
         model(op, a, b, r, c, d, elat);
         exec_op(op, a, b, 1'b1, lat, bc);
         n_tests++;
         if (lat !== elat || bc !== elat || ALU_rez !== r || carry !== c || div0 !== d || zero !== (r == 16'd0)) begin
            n_fail++;
            $display("FAIL random_op%0d: op=%0d a=%h b=%h got lat=%0d busy=%0d rez=%h c=%b d0=%b z=%b, want lat=%0d rez=%h c=%b d0=%b z=%b",
                     n, op, a, b, lat, bc, ALU_rez, carry, div0, zero, elat, r, c, d, (r == 16'd0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_mul();
      test_div();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-003 SHALL have port: start  input  1  operation request, sampled only in IDLE.
REQ-004 SHALL have port: opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT op_a, 110 MUL, 111 DIV.
REQ-005 SHALL have port: op_a  input  16  first operand (accumulator value).
REQ-006 SHALL have port: op_b  input  16  second operand.
REQ-007 SHALL have port: ALU_rez  output  16  registered result, held until the next result.
REQ-008 SHALL have port: str_rez  output  1  one-cycle store strobe to the accumulator, high only when ALU_rez is new.
REQ-009 SHALL have port: busy  output  1  high while a multi-cycle operation iterates.
REQ-010 SHALL have port: zero  output  1  registered, ALU_rez == 0.
REQ-011 SHALL have port: carry  output  1  registered; ADD carry-out, SUB borrow (op_a < op_b), 0 for other ops.
REQ-012 SHALL have port: div0  output  1  registered; 1 when the last result was DIV with op_b == 0.

Function
REQ-013 SHALL implement FSM states IDLE and EXEC; result delivery is a registered pulse on return to IDLE.
REQ-014 SHALL, in IDLE with start=1 at edge k, latch opcode, op_a and op_b at edge k.
REQ-015 SHALL, for opcodes 000-101, load ALU_rez, flags and str_rez=1 at edge k, remaining in IDLE (latency 1).
REQ-016 SHALL compute ADD and SUB modulo 2^16; AND/OR/XOR bitwise; NOT as ~op_a.
REQ-017 SHALL, for MUL, enter EXEC at edge k and perform 16 shift-add iterations at edges k+1..k+16; ALU_rez = low 16 bits of unsigned product.
REQ-018 SHALL, for DIV with op_b != 0, perform 16 restoring iterations at edges k+1..k+16; ALU_rez = unsigned quotient, remainder discarded.
REQ-019 SHALL load the MUL/DIV result, flags and str_rez=1 at edge k+16 and return to IDLE at that edge.
REQ-020 SHALL treat DIV with op_b == 0 as single-cycle: ALU_rez=16'hFFFF, div0=1, carry=0, str_rez=1 at edge k, no EXEC.
REQ-021 SHALL drive busy=1 in cycles following edges k..k+15 of MUL/DIV and busy=0 otherwise.
REQ-022 SHALL drive str_rez=1 for exactly one cycle per accepted operation; cleared at the next edge unless a new single-cycle op completes there.
REQ-023 SHALL ignore start while busy=1; no queuing.
REQ-024 SHALL accept start in the same cycle that str_rez=1 (back-to-back), giving continuous str_rez for consecutive single-cycle ops.
REQ-025 SHALL ignore changes to opcode, op_a and op_b after edge k until the operation completes.
REQ-026 SHALL leave ALU_rez, zero, carry and div0 unchanged between results.

Reset
REQ-027 SHALL, while reset=0, force ALU_rez=16'h0000, str_rez=0, busy=0, zero=0, carry=0, div0=0, state IDLE and iteration counter 0.
REQ-028 SHALL abandon any in-flight MUL/DIV on reset assertion; no str_rez pulse for it after release.
REQ-029 SHALL accept start at the first rising edge after reset returns high.

Verification
REQ-030 SHALL verify: reset low -> all outputs 0; release; ADD op_a=FFFF, op_b=0001 -> after edge k: ALU_rez=0000, carry=1, zero=1, str_rez high one cycle.
REQ-031 SHALL verify: SUB 0FFF-1000 -> ALU_rez=FFFF, carry=1, zero=0; then back-to-back AND FF01&0FFF -> next cycle ALU_rez=0F01, str_rez high 2 consecutive cycles.
REQ-032 SHALL verify: MUL 0123*0010 -> busy high 16 cycles, str_rez after edge k+16, ALU_rez=1230; operand changes during EXEC have no effect.
REQ-033 SHALL verify: DIV FF01/000F -> ALU_rez=1100 at edge k+16, div0=0; DIV 1234/0000 -> ALU_rez=FFFF, div0=1 at edge k, busy never high.
REQ-034 SHALL verify: start pulsed during MUL busy -> ignored, exactly one str_rez pulse, result unchanged.
REQ-035 SHALL verify: reset asserted mid-MUL (after edge k+8, between edges) -> outputs 0 immediately, no str_rez after release, next ADD 0001+0001 -> ALU_rez=0002.
